// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin HC-SR04 trigger/echo scheduler
// One sensor pings per slot; echo width is timed in microseconds and reported with its sensor id.
module sonar_scheduler #(
  parameter int NUM_SENSORS  = 4,
  parameter int CLK_PER_US   = 40,
  parameter int TRIG_US      = 20,
  parameter int SLOT_US      = 60000,
  parameter int ECHO_WAIT_US = 5000,
  parameter int MAX_US       = 4095,
  localparam int IDW = $clog2(NUM_SENSORS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [11:0]            result,
  output logic [IDW-1:0]         result_id,
  output logic                   result_valid,
  output logic                   result_timeout,
  output logic                   busy
);

  localparam int DIV_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int SPAN_US = (SLOT_US > TRIG_US + ECHO_WAIT_US) ? SLOT_US : TRIG_US + ECHO_WAIT_US;
  localparam int SLOT_W  = $clog2(SPAN_US + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_PER_US - 1);
  localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(TRIG_US - 1);
  localparam logic [SLOT_W-1:0] WAIT_LAST = SLOT_W'(TRIG_US + ECHO_WAIT_US - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_US - 1);
  localparam logic [11:0]       MAX_W     = 12'(MAX_US);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t                  state, state_n;
  logic [IDW-1:0]          cur, cur_n, next_sel, hi_sel, lo_sel;
  logic                    found_hi;
  logic [DIV_W-1:0]        div;
  logic [SLOT_W-1:0]       slot_us;
  logic [11:0]             width, width_n;
  logic [NUM_SENSORS-1:0]  echo_s1, echo_s2, trig_n;
  logic                    tick, slot_end, can_go, echo_cur, start;
  logic                    rep, rep_to;
  logic [11:0]             rep_val;

  assign busy     = (state != IDLE);
  assign tick     = busy && (div == DIV_LAST);
  assign slot_end = tick && (slot_us == SLOT_LAST);
  assign can_go   = enable && (|sensor_mask);
  assign echo_cur = echo_s2[cur];

  // First set mask bit strictly after cur, else the lowest set bit (wrap, possibly cur itself).
  always_comb begin
    found_hi = 1'b0;
    hi_sel   = cur;
    lo_sel   = cur;
    for (int j = NUM_SENSORS - 1; j >= 0; j--) begin
      if (sensor_mask[j]) begin
        if (IDW'(j) > cur) begin
          hi_sel   = IDW'(j);
          found_hi = 1'b1;
        end else begin
          lo_sel = IDW'(j);
        end
      end
    end
    next_sel = found_hi ? hi_sel : lo_sel;
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    width_n = width;
    rep     = 1'b0;
    rep_val = MAX_W;
    rep_to  = 1'b0;
    start   = 1'b0;
    trig_n  = '0;
    case (state)
      IDLE: begin
        if (can_go) start = 1'b1;
      end
      TRIG: begin
        if (tick && (slot_us == TRIG_LAST)) state_n = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (slot_end) begin
          rep    = 1'b1;
          rep_to = 1'b1;
        end else if (echo_cur) begin
          state_n = MEASURE;
          width_n = '0;
        end else if (tick && (slot_us == WAIT_LAST)) begin
          rep     = 1'b1;
          rep_to  = 1'b1;
          state_n = HOLDOFF;
        end
      end
      MEASURE: begin
        if (slot_end) begin
          rep     = 1'b1;
          rep_val = width;
          rep_to  = 1'b1;
        end else if (!echo_cur) begin
          rep     = 1'b1;
          rep_val = width;
          rep_to  = (width == MAX_W);
          state_n = HOLDOFF;
        end else if (tick && (width != MAX_W)) begin
          width_n = width + 12'd1;
        end
      end
      HOLDOFF: ;
      default: state_n = IDLE;
    endcase
    // Slot boundary: enable/mask are only sampled here and in IDLE.
    if (slot_end && (state != IDLE)) begin
      if (can_go) start = 1'b1;
      else        state_n = IDLE;
    end
    if (start) begin
      state_n = TRIG;
      cur_n   = next_sel;
    end
    if (state_n == TRIG) trig_n[cur_n] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur            <= IDW'(NUM_SENSORS - 1);
      div            <= '0;
      slot_us        <= '0;
      width          <= '0;
      echo_s1        <= '0;
      echo_s2        <= '0;
      trig           <= '0;
      result         <= '0;
      result_id      <= '0;
      result_valid   <= 1'b0;
      result_timeout <= 1'b0;
    end else begin
      cur     <= cur_n;
      width   <= width_n;
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      trig    <= trig_n;
      if (start || (state_n == IDLE)) begin
        div     <= '0;
        slot_us <= '0;
      end else begin
        div <= tick ? '0 : div + DIV_W'(1);
        if (tick) slot_us <= slot_us + SLOT_W'(1);
      end
      result_valid <= rep;
      if (rep) begin
        result         <= rep_val;
        result_id      <= cur;
        result_timeout <= rep_to;
      end
    end
  end

endmodule

// File: doc/sonar_scheduler.md
Name: sonar_scheduler

Overview:
- Time-multiplexes up to NUM_SENSORS HC-SR04 ultrasonic sensors so that only one sensor pings at a time. This prevents acoustic crosstalk between sensors.
- Steps round-robin through the enabled sensors. For each one it generates the trigger pulse, times the echo in microseconds, and then holds off until the slot period ends.
- Publishes each echo width with a sensor ID and a one-cycle valid strobe. Downstream intensity mapping and haptic drive consume this result.

Parameters:
- NUM_SENSORS, 4, number of sensors sharing the scheduler (2..8).
- CLK_PER_US, 40, clk cycles per microsecond (40 MHz clk).
- TRIG_US, 20, trigger high time in us.
- SLOT_US, 60000, full per-sensor slot length in us, counted from trig rise.
- ECHO_WAIT_US, 5000, max us from trig fall to echo rise before declaring no-return.
- MAX_US, 4095, saturation value of echo width; must fit in 12 bits.

Ports:
- clk, input, 1, 40 MHz system clock.
- reset, input, 1, asynchronous, active-low reset.
- enable, input, 1, run scheduling when high.
- sensor_mask, input, NUM_SENSORS, bit i high = sensor i participates.
- echo, input, NUM_SENSORS, raw asynchronous echo pins.
- trig, output, NUM_SENSORS, trigger pins; at most one bit high.
- result, output, 12, last echo width in us (saturating).
- result_id, output, clog2(NUM_SENSORS), sensor index of result.
- result_valid, output, 1, one-clk strobe when result/result_id/result_timeout update.
- result_timeout, output, 1, echo never rose, or width saturated, for this result.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (reset low, async): state=IDLE; trig=0, result=0, result_id=0, result_valid=0, result_timeout=0, busy=0. Current pointer cur=NUM_SENSORS-1, so the first search starts at sensor 0.
- Each echo bit passes through a 2-flop synchronizer (reset to 0). All echo decisions use the synchronized value, so there are 2 clk of latency.
- us tick: divider counts 0..CLK_PER_US-1 and pulses tick on the terminal count. Divider is held at 0 in IDLE and restarts at 0 on entry to TRIG.
- slot_us counter: cleared on entry to TRIG, increments on tick.
- Next-sensor search: first set bit of sensor_mask strictly after cur, wrapping modulo NUM_SENSORS. If the only set bit is cur, cur is selected again.
- IDLE: if enable=1 and sensor_mask!=0, the next clk loads cur with the next sensor and enters TRIG. trig[cur] rises on that same edge, so trig rises 1 clk after the qualifying inputs.
- TRIG: trig[cur]=1 for exactly TRIG_US*CLK_PER_US clk. Then trig=0, enter WAIT_RISE, clear wait counter.
- WAIT_RISE: wait counter increments per tick.
  - Synced echo[cur]=1: enter MEASURE with width=0.
  - Wait counter reaching ECHO_WAIT_US: report result=MAX_US, result_timeout=1, enter HOLDOFF.
- MEASURE: width increments per tick while synced echo[cur]=1, saturating at MAX_US.
  - On synced echo[cur]=0: report width, with result_timeout=1 iff width==MAX_US. Enter HOLDOFF.
- Report = one clk with result_valid=1; result, result_id=cur and result_timeout load on the same edge and hold until the next report.
- HOLDOFF: wait until slot_us reaches SLOT_US-1 and a tick occurs.
  - If enable=1 and sensor_mask!=0: select next sensor and enter TRIG (back-to-back, no IDLE cycle).
  - Otherwise enter IDLE.
- Slot end while still in WAIT_RISE or MEASURE: the report is forced on that cycle.
  - From WAIT_RISE: MAX_US, timeout=1.
  - From MEASURE: current width, timeout=1.
  - Transition then proceeds as from HOLDOFF.
- enable falling or sensor_mask changing mid-slot: the current slot completes and reports normally. The new values are only sampled at slot end / in IDLE.
- Exactly one report per slot; never two valid strobes within one slot.
- Echo on non-selected sensors is ignored.
- Reset asserted mid-slot: trig drops immediately (async). No report is issued for the aborted slot.

Test Plan:
Sim parameters: CLK_PER_US=4, TRIG_US=20, SLOT_US=300, ECHO_WAIT_US=100, MAX_US=150.
- Reset: hold reset low, toggle echo -> all outputs 0, busy=0. Release with enable=0 -> stays IDLE.
- Single sensor, mask=0001, enable=1: trig[0] high exactly 80 clk. Echo rises 40 us after trig fall, stays high 90 us -> result=90 (±1), result_id=0, result_timeout=0, one valid strobe. Next trig[0] rises 1200 clk after the first.
- Round-robin, mask=1011: trig order 0,1,3,0. Only one trig bit high at a time. result_id sequence 0,1,3,0.
- No echo: echo held 0 -> valid 100 us after trig fall with result=150, result_timeout=1.
- Stuck echo: echo held 1 -> result saturates; report at slot end with result=150, result_timeout=1.
- Control changes: drop enable mid-MEASURE -> slot still reports, then IDLE, busy=0. Assert reset mid-TRIG -> trig=0 immediately, no valid strobe.
